// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with registered colour/syncs and line/frame start pulses
module vga_timing_gen #(
  parameter int   HACTIVE = 640,
  parameter int   HFP     = 16,
  parameter int   HSYNC   = 96,
  parameter int   HBP     = 48,
  parameter int   VACTIVE = 480,
  parameter int   VFP     = 10,
  parameter int   VSYNC   = 2,
  parameter int   VBP     = 33,
  parameter logic HPOL    = 1'b0,
  parameter logic VPOL    = 1'b0,
  parameter int   BPP     = 2,
  parameter int   XW      = 10,
  parameter int   YW      = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  input  logic [BPP-1:0] red_in,
  input  logic [BPP-1:0] grn_in,
  input  logic [BPP-1:0] blu_in,
  output logic [BPP-1:0] vga_red,
  output logic [BPP-1:0] vga_grn,
  output logic [BPP-1:0] vga_blu,
  output logic           vga_hsync,
  output logic           vga_vsync,
  output logic           active,
  output logic [XW-1:0]  xpos,
  output logic [YW-1:0]  ypos,
  output logic           line_start,
  output logic           frame_start
);

  localparam logic [31:0] H_LAST   = 32'(HACTIVE + HFP + HSYNC + HBP - 1);
  localparam logic [31:0] V_LAST   = 32'(VACTIVE + VFP + VSYNC + VBP - 1);
  localparam logic [31:0] H_ACT    = 32'(HACTIVE);
  localparam logic [31:0] V_ACT    = 32'(VACTIVE);
  localparam logic [31:0] HS_START = 32'(HACTIVE + HFP);
  localparam logic [31:0] HS_END   = 32'(HACTIVE + HFP + HSYNC);
  localparam logic [31:0] VS_START = 32'(VACTIVE + VFP);
  localparam logic [31:0] VS_END   = 32'(VACTIVE + VFP + VSYNC);

  logic [XW-1:0]  hcount_q, hcount_d;
  logic [YW-1:0]  vcount_q, vcount_d;
  logic [BPP-1:0] red_q, grn_q, blu_q;
  logic           hsync_q, vsync_q;
  logic           line_start_q, frame_start_q;
  logic [31:0]    hx, vx;
  logic           h_wrap, v_wrap, hsync_raw, vsync_raw;

  // Compare in 32 bits so zero-width back porches (sync end == total) never overflow XW/YW.
  assign hx = 32'(hcount_q);
  assign vx = 32'(vcount_q);

  always_comb begin
    h_wrap    = (hx == H_LAST);
    v_wrap    = (vx == V_LAST);
    hsync_raw = (hx >= HS_START) && (hx < HS_END);
    vsync_raw = (vx >= VS_START) && (vx < VS_END);
    active    = (hx < H_ACT) && (vx < V_ACT);
    hcount_d  = h_wrap ? '0 : hcount_q + XW'(1);
    vcount_d  = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? '0 : vcount_q + YW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      red_q         <= '0;
      grn_q         <= '0;
      blu_q         <= '0;
      hsync_q       <= ~HPOL;
      vsync_q       <= ~VPOL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // Pulses drop after one clk even when pix_en stalls the counters.
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_en) begin
        hcount_q      <= hcount_d;
        vcount_q      <= vcount_d;
        red_q         <= active ? red_in : '0;
        grn_q         <= active ? grn_in : '0;
        blu_q         <= active ? blu_in : '0;
        hsync_q       <= hsync_raw ? HPOL : ~HPOL;
        vsync_q       <= vsync_raw ? VPOL : ~VPOL;
        line_start_q  <= h_wrap;
        frame_start_q <= h_wrap && v_wrap;
      end
    end
  end

  assign xpos        = hcount_q;
  assign ypos        = vcount_q;
  assign vga_red     = red_q;
  assign vga_grn     = grn_q;
  assign vga_blu     = blu_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against a tick-count raster model
module tb_vga_timing_gen;

  localparam int   HA = 4, HFP = 1, HS = 2, HBP = 1;
  localparam int   VA = 3, VFP = 1, VS = 1, VBP = 1;
  localparam int   HT = HA + HFP + HS + HBP;
  localparam int   VT = VA + VFP + VS + VBP;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b1;
  localparam int   BPP = 2, XW = 3, YW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           pix_en = 1'b0;
  logic [BPP-1:0] red_in = '0, grn_in = '0, blu_in = '0;
  logic [BPP-1:0] vga_red, vga_grn, vga_blu;
  logic           vga_hsync, vga_vsync, active, line_start, frame_start;
  logic [XW-1:0]  xpos;
  logic [YW-1:0]  ypos;

  vga_timing_gen #(
    .HACTIVE(HA), .HFP(HFP), .HSYNC(HS), .HBP(HBP),
    .VACTIVE(VA), .VFP(VFP), .VSYNC(VS), .VBP(VBP),
    .HPOL(HPOL), .VPOL(VPOL), .BPP(BPP), .XW(XW), .YW(YW)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .red_in(red_in), .grn_in(grn_in), .blu_in(blu_in),
    .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .active(active),
    .xpos(xpos), .ypos(ypos), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   x, y, red, grn, blu;
    logic act, hs, vs, ls, fs;
    int   k, ph;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: raster position is just the number of pix_en ticks since reset.
  int   m_t, m_k, m_red, m_grn, m_blu;
  logic m_hs, m_vs, m_ls, m_fs;

  task automatic chk(input string name, input int k, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s k=%0d got=%0d want=%0d", name, k, act_v, exp_v);
    end
  endtask

  task automatic step(input logic rst, input logic pe, input int r, input int g, input int b, input int ph);
    exp_t e;
    int h, v;
    logic a;
    reset  = rst;
    pix_en = pe;
    red_in = BPP'(r);
    grn_in = BPP'(g);
    blu_in = BPP'(b);
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_k = 0; m_red = 0; m_grn = 0; m_blu = 0;
      m_hs = ~HPOL; m_vs = ~VPOL; m_ls = 1'b0; m_fs = 1'b0;
    end else begin
      m_k++;
      m_ls = 1'b0;
      m_fs = 1'b0;
      if (pe) begin
        h = m_t % HT;
        v = (m_t / HT) % VT;
        a = (h < HA) && (v < VA);
        m_red = a ? r : 0;
        m_grn = a ? g : 0;
        m_blu = a ? b : 0;
        m_hs = (h >= HA + HFP && h < HA + HFP + HS) ? HPOL : ~HPOL;
        m_vs = (v >= VA + VFP && v < VA + VFP + VS) ? VPOL : ~VPOL;
        m_t++;
        m_ls = (m_t % HT) == 0;
        m_fs = (m_t % (HT * VT)) == 0;
      end
    end
    e.x = m_t % HT;
    e.y = (m_t / HT) % VT;
    e.act = (e.x < HA) && (e.y < VA);
    e.red = m_red; e.grn = m_grn; e.blu = m_blu;
    e.hs = m_hs; e.vs = m_vs; e.ls = m_ls; e.fs = m_fs;
    e.k = m_k; e.ph = ph;
    q.push_back(e);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("xpos", e.k, 32'(xpos), e.x);
        chk("ypos", e.k, 32'(ypos), e.y);
        chk("active", e.k, 32'(active), 32'(e.act));
        chk("vga_red", e.k, 32'(vga_red), e.red);
        chk("vga_grn", e.k, 32'(vga_grn), e.grn);
        chk("vga_blu", e.k, 32'(vga_blu), e.blu);
        chk("vga_hsync", e.k, 32'(vga_hsync), 32'(e.hs));
        chk("vga_vsync", e.k, 32'(vga_vsync), 32'(e.vs));
        chk("line_start", e.k, 32'(line_start), 32'(e.ls));
        chk("frame_start", e.k, 32'(frame_start), 32'(e.fs));
        // Fixed expectations for directed scenarios, independent of the model.
        if (e.ph == 1) begin
          if (e.k >= 1 && e.k <= 8) begin
            chk("dir_hsync", e.k, 32'(vga_hsync), (e.k == 6 || e.k == 7) ? 0 : 1);
            chk("dir_red_line0", e.k, 32'(vga_red), (e.k <= 4) ? 3 : 0);
          end
          if (e.k >= 24 && e.k <= 47) chk("dir_red_blank", e.k, 32'(vga_red), 0);
          chk("dir_line_start", e.k, 32'(line_start), (e.k > 0 && e.k % 8 == 0) ? 1 : 0);
          chk("dir_frame_start", e.k, 32'(frame_start), (e.k == 48 || e.k == 96) ? 1 : 0);
          if (e.k >= 1 && e.k <= 48) chk("dir_vsync", e.k, 32'(vga_vsync), (e.k >= 33 && e.k <= 40) ? 1 : 0);
        end
        if (e.ph == 2 && e.k <= 20) begin
          chk("dir_stall_xpos", e.k, 32'(xpos), ((e.k + 1) / 2) % 8);
          if (e.k >= 1 && e.k <= 16) chk("dir_stall_hsync", e.k, 32'(vga_hsync), (e.k >= 11 && e.k <= 14) ? 0 : 1);
          chk("dir_stall_ls", e.k, 32'(line_start), (e.k == 15) ? 1 : 0);
        end
        if (e.ph == 3) begin
          if (e.k == 0) begin
            chk("dir_rst_pos", e.k, {16'(xpos), 16'(ypos)}, 0);
            chk("dir_rst_colour", e.k, 32'({vga_red, vga_grn, vga_blu}), 0);
            chk("dir_rst_syncs", e.k, 32'({vga_hsync, vga_vsync}), 32'({~HPOL, ~VPOL}));
            chk("dir_rst_ls", e.k, 32'(line_start), 0);
          end
          if (e.k <= 60) chk("dir_rst_fs", e.k, 32'(frame_start), (e.k == 48) ? 1 : 0);
        end
      end
    end
  end

  initial begin : stimulus
    // Constant red and full-rate pixel clock.
    step(1'b1, 1'b1, 3, 0, 0, 1);
    for (int i = 1; i <= 100; i++) step(1'b0, 1'b1, 3, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1);

    // pix_en alternating, starting with 1 on the first edge after reset.
    step(1'b1, 1'b1, 0, 0, 0, 2);
    for (int i = 1; i <= 24; i++) step(1'b0, logic'(i % 2), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2);

    // Reset mid-frame at hcount=3, vcount=2.
    step(1'b1, 1'b1, 0, 0, 0, 0);
    for (int i = 1; i <= 19; i++) step(1'b0, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    step(1'b1, 1'b1, 3, 3, 3, 3);
    for (int i = 1; i <= 60; i++) step(1'b0, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 3);

    // Random pix_en, colours and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4);
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drain", 0, 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001: The block SHALL have parameter HACTIVE, default 640, visible pixels per line.
- REQ-002: The block SHALL have parameter HFP, default 16, horizontal front porch in pixels.
- REQ-003: The block SHALL have parameter HSYNC, default 96, horizontal sync width in pixels.
- REQ-004: The block SHALL have parameter HBP, default 48, horizontal back porch in pixels.
- REQ-005: The block SHALL have parameters VACTIVE, VFP, VSYNC and VBP, defaults 480, 10, 2 and 33, which are the vertical equivalents in lines.
- REQ-006: The block SHALL have parameters HPOL and VPOL, default 0 each, giving the asserted sync level (0 = active-low).
- REQ-007: The block SHALL have parameter BPP, default 2, bits per colour channel.
- REQ-008: The block SHALL have parameters XW and YW, default 10 each, giving the counter widths.
- REQ-009: XW SHALL hold HTOTAL-1 and YW SHALL hold VTOTAL-1, where HTOTAL = HACTIVE+HFP+HSYNC+HBP and VTOTAL = VACTIVE+VFP+VSYNC+VBP.
- REQ-010: The block SHALL have port clk, input, 1 bit: single clock.
- REQ-011: The block SHALL have port reset, input, 1 bit: synchronous, active-high.
- REQ-012: The block SHALL have port pix_en, input, 1 bit: pixel-clock enable; all state advances only on cycles where it is 1.
- REQ-013: The block SHALL have ports red_in, grn_in and blu_in, each input, BPP bits: pixel colour for the current xpos/ypos.
- REQ-014: The block SHALL have ports vga_red, vga_grn and vga_blu, each output, BPP bits: registered colour.
- REQ-015: The block SHALL have ports vga_hsync and vga_vsync, each output, 1 bit: registered syncs.
- REQ-016: The block SHALL have port active, output, 1 bit: current counters are in the visible region.
- REQ-017: The block SHALL have ports xpos and ypos, outputs, XW and YW bits: current hcount and vcount.
- REQ-018: The block SHALL have ports line_start and frame_start, each output, 1 bit: start-of-line and start-of-frame pulses.
- REQ-019: One clock domain SHALL be used, and reset SHALL be synchronous and active-high.

Function
- REQ-020: On a pix_en=1 cycle, hcount SHALL increment, wrapping from HTOTAL-1 to 0.
- REQ-021: On that hcount wrap, vcount SHALL increment, wrapping from VTOTAL-1 to 0.
- REQ-022: On pix_en=0 cycles, all counters and registered outputs SHALL hold.
- REQ-023: active SHALL be combinational and equal (hcount < HACTIVE) && (vcount < VACTIVE).
- REQ-024: xpos SHALL equal hcount and ypos SHALL equal vcount.
- REQ-025: Raw hsync SHALL be true for HACTIVE+HFP <= hcount < HACTIVE+HFP+HSYNC.
- REQ-026: Raw vsync SHALL be true for VACTIVE+VFP <= vcount < VACTIVE+VFP+VSYNC; it is line-based and not offset within the line.
- REQ-027: On each pix_en=1 cycle, vga_hsync SHALL be registered as HPOL if raw hsync is true, else ~HPOL; vga_vsync likewise with VPOL.
- REQ-028: On each pix_en=1 cycle, the colour outputs SHALL register the *_in values if active is 1, else 0.
- REQ-029: Latency: colour and syncs SHALL lag the counters by exactly one pix_en tick, so that colour and syncs stay mutually aligned.
- REQ-030: line_start SHALL be high for exactly one clk cycle, the first cycle in which hcount holds 0 as the result of a wrap.
- REQ-031: frame_start SHALL be high for exactly one clk cycle, the first cycle in which (hcount, vcount) holds (0,0) as the result of a wrap; line_start is also high in that cycle.
- REQ-032: If pix_en is low after a wrap, the pulses SHALL still be exactly one clk cycle long.
- REQ-033: Parameters of 1 for any porch or sync SHALL work, and zero-width porches SHALL be supported.
- REQ-034: Parameters violating REQ-009 are out of scope.

Reset
- REQ-035: reset SHALL take priority over pix_en.
- REQ-036: On the clk edge with reset=1, hcount and vcount SHALL be set to 0.
- REQ-037: On the clk edge with reset=1, colour outputs SHALL be set to 0.
- REQ-038: On the clk edge with reset=1, vga_hsync SHALL be set to ~HPOL and vga_vsync to ~VPOL.
- REQ-039: On the clk edge with reset=1, line_start and frame_start SHALL be set to 0.
- REQ-040: Leaving reset SHALL NOT generate a line_start or frame_start pulse; the first pulses follow the first natural wrap.
- REQ-041: Reset asserted mid-frame SHALL behave identically to power-on reset.

Verification
Bench parameters: HACTIVE=4, HFP=1, HSYNC=2, HBP=1 (HTOTAL=8); VACTIVE=3, VFP=1, VSYNC=1, VBP=1 (VTOTAL=6); BPP=2. "Cycle k" is the k-th clk after reset deasserts, counting from 0. pix_en=1 unless stated.
- REQ-042: With HPOL=0, the bench SHALL check: hcount=5,6 in cycles 5,6 -> vga_hsync=0 in cycles 6,7 and 1 in cycles 1-5 and 8.
- REQ-043: The bench SHALL check: red_in=3 held constant -> vga_red=3 in cycles 1-4 and 0 in cycles 5-8; vga_red=0 in every cycle of lines 3-5.
- REQ-044: The bench SHALL check: line_start=1 only in cycles 8, 16, …; frame_start=1 only in cycles 48 and 96; no pulse in cycle 0.
- REQ-045: With VPOL=1, the bench SHALL check: vga_vsync=1 in cycles 33-40 and 0 elsewhere in the frame.
- REQ-046: The bench SHALL check: pix_en toggling 1,0,1,0 -> counters advance every second cycle; vga_hsync stays low 4 clk cycles; line_start stays 1 clk wide.
- REQ-047: The bench SHALL check: reset asserted at hcount=3, vcount=2 -> next cycle xpos=0, ypos=0, colours 0, syncs at the inactive level, no frame_start; the first frame_start then appears 48 ticks later.
